// File: rtl/pl_wb_arbiter.sv
// rtl/pl_wb_arbiter.sv - register-file write-port arbiter: pipeline WB (A) vs buffered multi-cycle unit (B)
// Optional starvation guard (stall_req/arb_err) compiled in with WB_ARB_STARVE_EN.
`timescale 1ns/1ps
module pl_wb_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        wb_valid,
  input  logic [4:0]  wb_reg,
  input  logic [31:0] wb_data,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_reg,
  input  logic [31:0] md_data,
  input  logic [4:0]  rs_q,
  input  logic [4:0]  rt_q,
  output logic        pend_rs,
  output logic        pend_rt,
  output logic        reg_write,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        stall_req,
  output logic        arb_err
);

  logic [4:0]  r_fifo_reg  [2];
  logic [31:0] r_fifo_data [2];
  logic        r_rd_ptr;
  logic        r_wr_ptr;
  logic [1:0]  r_count;

  logic        w_push;
  logic        w_pop;
  logic        w_a_grant;
  logic        w_head_valid;
  logic        w_tail_valid;
  logic [4:0]  w_head_reg;
  logic [31:0] w_head_data;
  logic [4:0]  w_tail_reg;

  assign md_ready     = (r_count != 2'd2);
  assign w_push       = md_valid && md_ready;
  assign w_a_grant    = reset_n && wb_valid && (wb_reg != 5'd0);
  // Any A request, even a reg-0 bubble, holds off draining the FIFO this cycle.
  assign w_pop        = reset_n && !wb_valid && enable && (r_count != 2'd0);
  assign w_head_valid = (r_count != 2'd0);
  assign w_tail_valid = (r_count == 2'd2);
  assign w_head_reg   = r_fifo_reg[r_rd_ptr];
  assign w_head_data  = r_fifo_data[r_rd_ptr];
  assign w_tail_reg   = r_fifo_reg[~r_rd_ptr];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_reg[r_wr_ptr]  <= md_reg;
      r_fifo_data[r_wr_ptr] <= md_data;
    end
  end

  assign pend_rs = (rs_q != 5'd0) &&
                   ((w_head_valid && (w_head_reg == rs_q)) || (w_tail_valid && (w_tail_reg == rs_q)));
  assign pend_rt = (rt_q != 5'd0) &&
                   ((w_head_valid && (w_head_reg == rt_q)) || (w_tail_valid && (w_tail_reg == rt_q)));

  always_comb begin
    reg_write  = 1'b0;
    write_reg  = 5'd0;
    write_data = 32'd0;
    if (w_a_grant) begin
      reg_write  = 1'b1;
      write_reg  = wb_reg;
      write_data = wb_data;
    end else if (w_pop && (w_head_reg != 5'd0)) begin
      reg_write  = 1'b1;
      write_reg  = w_head_reg;
      write_data = w_head_data;
    end
  end

`ifdef WB_ARB_STARVE_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] r_starve_cnt;
  logic [CW-1:0] w_starve_next;
  logic          r_stall;
  logic          r_err;

  // Saturates at the limit; cleared by any pop or an empty FIFO.
  always_comb begin
    w_starve_next = r_starve_cnt;
    if (w_pop || !w_head_valid)
      w_starve_next = '0;
    else if (r_starve_cnt != LIMIT)
      w_starve_next = r_starve_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_starve_cnt <= '0;
      r_stall      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_starve_cnt <= w_starve_next;
      r_stall      <= (w_starve_next == LIMIT);
      if (w_a_grant && r_stall) r_err <= 1'b1;
    end
  end

  assign stall_req = r_stall;
  assign arb_err   = r_err;
`else
  logic w_unused_limit;
  assign w_unused_limit = (STARVE_LIMIT != 0);
  assign stall_req = 1'b0;
  assign arb_err   = 1'b0;
`endif

endmodule

// File: tb/tb_pl_wb_arbiter.sv
// tb/tb_pl_wb_arbiter.sv - directed self-checking bench for pl_wb_arbiter
`timescale 1ns/1ps
module tb_pl_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic [4:0]  rs_q;
  logic [4:0]  rt_q;
  logic        pend_rs;
  logic        pend_rt;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        stall_req;
  logic        arb_err;

  int checks   = 0;
  int failures = 0;

`ifdef WB_ARB_STARVE_EN
  localparam logic [31:0] STARVE = 32'd1;
`else
  localparam logic [31:0] STARVE = 32'd0;
`endif

  always #5 clk = ~clk;

  pl_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .rs_q(rs_q), .rt_q(rt_q), .pend_rs(pend_rs), .pend_rt(pend_rt),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .stall_req(stall_req), .arb_err(arb_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic [4:0] r, input logic [31:0] d);
    wb_valid = v; wb_reg = r; wb_data = d;
  endtask

  task automatic set_b(input logic v, input logic [4:0] r, input logic [31:0] d);
    md_valid = v; md_reg = r; md_data = d;
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1;
    set_a(1'b0, 5'd0, 32'd0);
    set_b(1'b1, 5'd5, 32'h1111);
    rs_q = 5'd5; rt_q = 5'd0;
    #2;
    chk("rst_ready", md_ready, 1);
    chk("rst_wr", reg_write, 0);
    chk("rst_pend", pend_rs, 0);
    chk("rst_stall", stall_req, 0);
    chk("rst_err", arb_err, 0);
    tick(); tick();
    chk("rst_ready_clk", md_ready, 1);
    chk("rst_pend_clk", pend_rs, 0);
    set_b(1'b0, 5'd0, 32'd0);
    reset_n = 1'b1;
    #3;
    chk("idle_wr", reg_write, 0);
    chk("idle_wreg", write_reg, 0);

    // B-only latency
    tick();
    set_b(1'b1, 5'd5, 32'hDEADBEEF); #3;
    chk("b_nobypass", reg_write, 0);
    chk("b_ready", md_ready, 1);
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("b_wr", reg_write, 1);
    chk("b_wreg", write_reg, 5);
    chk("b_wdata", write_data, 32'hDEADBEEF);
    chk("b_pend", pend_rs, 1);
    tick(); #3;
    chk("b_empty_wr", reg_write, 0);
    chk("b_empty_wdata", write_data, 0);
    chk("b_empty_pend", pend_rs, 0);

    // Contention: A keeps the port while reg 7 waits
    tick();
    set_a(1'b1, 5'd3, 32'h33);
    set_b(1'b1, 5'd7, 32'h77); #3;
    chk("c0_wreg", write_reg, 3);
    tick();
    set_b(1'b0, 5'd0, 32'd0); rs_q = 5'd7; #3;
    chk("c1_wr", reg_write, 1);
    chk("c1_wreg", write_reg, 3);
    chk("c1_wdata", write_data, 32'h33);
    chk("c1_pend_rs", pend_rs, 1);
    tick(); #3;
    chk("c2_wreg", write_reg, 3);
    tick();
    set_a(1'b0, 5'd0, 32'd0); #3;
    chk("c3_wr", reg_write, 1);
    chk("c3_wreg", write_reg, 7);
    chk("c3_wdata", write_data, 32'h77);

    // Full FIFO, held third request, simultaneous push/pop at count 1
    tick();
    set_a(1'b1, 5'd3, 32'h33);
    set_b(1'b1, 5'd8, 32'h88); rs_q = 5'd8; rt_q = 5'd9; #3;
    chk("f0_ready", md_ready, 1);
    tick();
    set_b(1'b1, 5'd9, 32'h99); #3;
    chk("f1_ready", md_ready, 1);
    tick();
    set_b(1'b1, 5'd10, 32'hAA); #3;
    chk("f2_ready", md_ready, 0);
    chk("f2_pend_rs", pend_rs, 1);
    chk("f2_pend_rt", pend_rt, 1);
    tick();
    set_a(1'b0, 5'd0, 32'd0); #3;
    chk("f3_ready", md_ready, 0);
    chk("f3_wreg", write_reg, 8);
    chk("f3_wdata", write_data, 32'h88);
    tick(); #3;
    chk("f4_ready", md_ready, 1);
    chk("f4_wreg", write_reg, 9);
    chk("f4_pend_rs", pend_rs, 0);
    tick();
    set_b(1'b0, 5'd0, 32'd0); rs_q = 5'd10; #3;
    chk("f5_wreg", write_reg, 10);
    chk("f5_wdata", write_data, 32'hAA);
    chk("f5_pend_rt", pend_rt, 0);
    tick(); #3;
    chk("f6_wr", reg_write, 0);

    // Push while enable=0; drain only once enabled
    enable = 1'b0;
    set_b(1'b1, 5'd12, 32'hC); rs_q = 5'd12; #3;
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("e_wr", reg_write, 0);
    chk("e_wreg", write_reg, 0);
    chk("e_pend", pend_rs, 1);
    tick();
    enable = 1'b1; #3;
    chk("e_drain", write_reg, 12);
    tick();

    // A request to reg 0 blocks draining
    set_a(1'b1, 5'd0, 32'h5); set_b(1'b1, 5'd13, 32'hD); #3;
    chk("z0_wr", reg_write, 0);
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("z1_wr", reg_write, 0);
    chk("z1_wreg", write_reg, 0);
    tick();
    set_a(1'b0, 5'd0, 32'd0); #3;
    chk("z2_wreg", write_reg, 13);
    tick();

    // B write to reg 0 is popped silently
    set_b(1'b1, 5'd0, 32'h55); rs_q = 5'd0; #3;
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("r0_wr", reg_write, 0);
    chk("r0_pend", pend_rs, 0);
    tick();
    set_a(1'b1, 5'd3, 32'h33); set_b(1'b1, 5'd14, 32'hE); #3;
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("r0_popped", md_ready, 1);
    tick();
    set_a(1'b0, 5'd0, 32'd0); #3;
    chk("r0_next", write_reg, 14);
    tick();

    // Starvation: A busy with reg 22 buffered
    set_a(1'b1, 5'd3, 32'h33); set_b(1'b1, 5'd22, 32'h22); #3;
    tick();
    set_b(1'b0, 5'd0, 32'd0); #3;
    chk("s1_stall", stall_req, 0);
    tick(); tick(); tick(); #3;
    chk("s4_stall", stall_req, 0);
    tick();
    set_a(1'b1, 5'd2, 32'h2); #3;
    chk("s5_stall", stall_req, STARVE);
    chk("s5_err", arb_err, 0);
    chk("s5_a_wins", write_reg, 2);
    tick();
    set_a(1'b0, 5'd0, 32'd0); #3;
    chk("s6_err", arb_err, STARVE);
    chk("s6_stall", stall_req, STARVE);
    chk("s6_wreg", write_reg, 22);
    tick(); #3;
    chk("s7_stall", stall_req, 0);
    chk("s7_err_sticky", arb_err, STARVE);

    // Reset mid-operation with two entries buffered
    set_a(1'b1, 5'd3, 32'h33); set_b(1'b1, 5'd20, 32'h20); rs_q = 5'd20; rt_q = 5'd21;
    tick();
    set_b(1'b1, 5'd21, 32'h21);
    tick();
    set_b(1'b0, 5'd0, 32'd0); #2;
    chk("m_full", md_ready, 0);
    reset_n = 1'b0; #1;
    chk("m_rst_ready", md_ready, 1);
    chk("m_rst_pend", pend_rs, 0);
    chk("m_rst_wr", reg_write, 0);
    chk("m_rst_err", arb_err, 0);
    tick();
    set_a(1'b0, 5'd0, 32'd0); reset_n = 1'b1; #3;
    chk("m_rel_wr", reg_write, 0);
    tick(); #3;
    chk("m_rel_wr2", reg_write, 0);
    chk("m_rel_pend", pend_rt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_wb_arbiter.md
PL_WB_ARBITER -- requirements
Module: pl_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive cycles a non-empty buffer may be denied before stall_req rises.
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  global advance; 0 freezes draining.
- wb_valid  in  1  pipeline WB write request (requester A).
- wb_reg  in  5  A destination register.
- wb_data  in  32  A write data.
- md_valid  in  1  multi-cycle unit write request (requester B).
- md_ready  out  1  B accept.
- md_reg  in  5  B destination register.
- md_data  in  32  B write data.
- rs_q  in  5  hazard query, source 1.
- rt_q  in  5  hazard query, source 2.
- pend_rs  out  1  rs_q matches a buffered B write.
- pend_rt  out  1  rt_q matches a buffered B write.
- reg_write  out  1  register-file write enable.
- write_reg  out  5  register-file write address.
- write_data  out  32  register-file write data.
- stall_req  out  1  request that the pipeline bubble WB.
- arb_err  out  1  sticky protocol-violation flag.

Function
REQ-003 SHALL buffer B requests in a 2-entry FIFO; push on rising clk when md_valid && md_ready.
REQ-004 SHALL drive md_ready = (count < 2), from registered count only; no same-cycle full bypass.
REQ-005 SHALL never bypass an empty FIFO: a B request reaches the write port no earlier than the cycle after its push.
REQ-006 SHALL grant A whenever wb_valid=1 and wb_reg!=0: reg_write=1, write_reg/write_data from A, combinationally.
REQ-007 SHALL grant the FIFO head when A has no grant, FIFO non-empty and enable=1; pop at that clk edge.
REQ-008 SHALL drop a FIFO head with reg 0 by popping it without asserting reg_write.
REQ-009 SHALL drive reg_write=0 when A has no grant and the FIFO is empty or enable=0; write_reg/write_data then SHALL be 0.
REQ-010 SHALL drive reg_write=0 for a wb_reg=0 request; the FIFO head SHALL NOT drain in that cycle.
REQ-011 SHALL on simultaneous push and pop at count 1 keep count 1, with the new entry becoming head.
REQ-012 SHALL accept pushes while enable=0.
REQ-013 SHALL assert pend_rs (pend_rt) when rs_q (rt_q) is nonzero and equals the reg field of any valid FIFO entry.
REQ-014 SHALL count consecutive cycles in which the FIFO is non-empty and the head is not popped; the count clears on any pop or when the FIFO is empty.
REQ-015 SHALL register stall_req=1 once the count reaches STARVE_LIMIT, holding it until the next pop.
REQ-016 SHALL set arb_err when wb_valid=1 and wb_reg!=0 while stall_req=1; A still wins in that case.
REQ-017 SHALL hold arb_err until reset.

Reset
REQ-018 SHALL on reset_n=0, immediately and independent of clk:
- empty the FIFO (count 0, pointers 0);
- clear the starvation counter, stall_req and arb_err;
- give md_ready=1, pend_rs=pend_rt=0, reg_write=0.
REQ-019 SHALL discard any buffered B write when reset is asserted mid-operation.

Configuration
REQ-020 SHALL compile the starvation guard (REQ-014..REQ-016) only when WB_ARB_STARVE_EN is defined.
REQ-021 SHALL without WB_ARB_STARVE_EN tie stall_req and arb_err to 0 and omit the counter; all other behaviour is unchanged.

Verification
REQ-022 SHALL cover these scenarios:
- Reset check: reset_n=0 with md_valid=1 -> md_ready=1, reg_write=0, pend_rs=0.
- B-only latency: md_valid=1, md_reg=5, md_data=0xDEADBEEF for one cycle, wb_valid=0 -> next cycle reg_write=1, write_reg=5, write_data=0xDEADBEEF; FIFO then empty.
- Contention: FIFO holds reg 7, wb_valid=1 wb_reg=3 for 2 cycles -> A written both cycles, pend_rs=1 for rs_q=7, reg 7 written the cycle wb_valid drops.
- Full FIFO: two B pushes (regs 8, 9) with A busy -> md_ready=0; third md_valid held; after one pop, md_ready=1.
- Starvation, WB_ARB_STARVE_EN defined, STARVE_LIMIT=4: A busy continuously with FIFO non-empty -> stall_req=1 after 4 denied cycles. If A then bubbles, head pops and stall_req clears. If A instead writes reg 2 while stall_req=1, arb_err=1.
- Reg 0 and reset mid-operation: B push to reg 0 -> popped with reg_write=0. Reset asserted with 2 entries buffered -> entries discarded, no write after release.
